// File: rtl/sodor_dmem_lb.sv
// Data memory with a small load buffer and a fixed miss latency.
// Hits and stores answer in one cycle; misses answer after MISS_LAT cycles.
module sodor_dmem_lb #(
  parameter int XLEN       = 32,
  parameter int ADDR_BITS  = 4,
  parameter int MISS_LAT   = 4,
  parameter int LB_ENTRIES = 4,
  parameter int LB_EN      = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_fcn,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_data,
  input  logic            flush,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_hit,
  output logic            busy
);

  localparam int RR_W  = (LB_ENTRIES > 1) ? $clog2(LB_ENTRIES) : 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                state;
  logic [XLEN-1:0]       mem      [DEPTH];
  logic [LB_ENTRIES-1:0] lb_valid;
  logic [ADDR_BITS-1:0]  lb_tag   [LB_ENTRIES];
  logic [XLEN-1:0]       lb_data  [LB_ENTRIES];
  logic [RR_W-1:0]       rr;
  logic [3:0]            cnt;
  logic [ADDR_BITS-1:0]  miss_idx;
  logic                  was_flushed;

  logic [ADDR_BITS-1:0]  idx;
  logic                  accept;
  logic [LB_ENTRIES-1:0] hit_vec;
  logic                  hit_any;
  logic [XLEN-1:0]       hit_data;
  logic [RR_W-1:0]       victim;
  logic                  has_invalid;
  logic                  fill_done;
  logic                  fill_en;
  logic [XLEN-1:0]       miss_rdata;
  logic                  unused_addr;

  // Upper and byte-offset address bits are deliberately ignored, so addresses alias.
  assign idx         = req_addr[ADDR_BITS+1:2];
  assign unused_addr = ^{req_addr[XLEN-1:ADDR_BITS+2], req_addr[1:0]};
  assign accept      = req_valid && (state == IDLE);
  assign miss_rdata  = mem[miss_idx];
  assign fill_done   = (state == MISS) && (cnt == 4'(MISS_LAT - 1));
  assign fill_en     = fill_done && (LB_EN != 0) && !was_flushed && !flush;

  // Victim search walks downward so the lowest-numbered invalid entry wins.
  always_comb begin
    hit_vec     = '0;
    hit_data    = '0;
    victim      = rr;
    has_invalid = 1'b0;
    for (int i = LB_ENTRIES - 1; i >= 0; i--) begin
      hit_vec[i] = lb_valid[i] && (lb_tag[i] == idx);
      if (hit_vec[i]) hit_data = hit_data | lb_data[i];
      if (!lb_valid[i]) begin
        victim      = RR_W'(i);
        has_invalid = 1'b1;
      end
    end
    hit_any = (LB_EN != 0) && (|hit_vec) && !flush;
  end

  always_ff @(posedge clk) begin
    if (!reset && accept && req_fcn) mem[idx] <= req_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lb_valid    <= '0;
      rr          <= '0;
      cnt         <= '0;
      miss_idx    <= '0;
      was_flushed <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_data   <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_data  <= '0;
      if (flush) lb_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_fcn) begin
              resp_valid <= 1'b1;
              for (int i = 0; i < LB_ENTRIES; i++) begin
                if (hit_vec[i]) lb_data[i] <= req_data;
              end
            end else if (hit_any) begin
              resp_valid <= 1'b1;
              resp_hit   <= 1'b1;
              resp_data  <= hit_data;
            end else begin
              miss_idx    <= idx;
              cnt         <= 4'd1;
              was_flushed <= 1'b0;
              state       <= MISS;
              req_ready   <= 1'b0;
              busy        <= 1'b1;
            end
          end
        end
        MISS: begin
          cnt <= cnt + 4'd1;
          if (flush) was_flushed <= 1'b1;
          if (fill_done) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b1;
            resp_data  <= miss_rdata;
            // A flush anywhere in the miss window suppresses the fill.
            if (fill_en) begin
              lb_valid[victim] <= 1'b1;
              lb_tag[victim]   <= miss_idx;
              lb_data[victim]  <= miss_rdata;
              if (!has_invalid)
                rr <= (rr == RR_W'(LB_ENTRIES - 1)) ? '0 : rr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sodor_dmem_lb.sv
// Directed bench for sodor_dmem_lb: a default instance, one with the buffer
// disabled and one with a two-cycle miss latency.
module tb_sodor_dmem_lb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  vld = '0;
  logic        fcn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;

  logic        rdy [3];
  logic        rv  [3];
  logic [31:0] rd  [3];
  logic        rh  [3];
  logic        bsy [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sodor_dmem_lb u_main (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_fcn(fcn), .req_addr(addr),
    .req_data(wdata), .flush(flush), .req_ready(rdy[0]), .resp_valid(rv[0]),
    .resp_data(rd[0]), .resp_hit(rh[0]), .busy(bsy[0])
  );

  sodor_dmem_lb #(.LB_EN(0)) u_nolb (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_fcn(fcn), .req_addr(addr),
    .req_data(wdata), .flush(flush), .req_ready(rdy[1]), .resp_valid(rv[1]),
    .resp_data(rd[1]), .resp_hit(rh[1]), .busy(bsy[1])
  );

  sodor_dmem_lb #(.MISS_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(vld[2]), .req_fcn(fcn), .req_addr(addr),
    .req_data(wdata), .flush(flush), .req_ready(rdy[2]), .resp_valid(rv[2]),
    .resp_data(rd[2]), .resp_hit(rh[2]), .busy(bsy[2])
  );

  typedef struct {
    logic        rst;
    logic        fcn;
    logic [31:0] addr;
    logic [31:0] data;
    logic        fl;
    logic        exp_hit;
    int          exp_lat;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [25];

  task automatic checkOutput(input string name, input int tag, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (%0d): got %h expected %h", name, tag, act, exp);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issues one request on instance inst and follows it until a response or a
  // 20-sample limit. flush_edge/reset_edge pick a sample after which a one-cycle
  // flush or reset is driven onto the following edge.
  task automatic applyStimulus(input int inst, input logic f, input logic [31:0] a,
                               input logic [31:0] d, input logic fl_acc,
                               input int flush_edge, input int reset_edge,
                               output int lat, output logic hit, output logic [31:0] data,
                               output int ready_low, output int busy_cnt, output bit got);
    @(negedge clk);
    fcn   = f;
    addr  = a;
    wdata = d;
    flush = fl_acc;
    vld[inst] = 1'b1;
    @(posedge clk);
    #1;
    vld   = '0;
    flush = 1'b0;
    lat = 1; got = 1'b0; hit = 1'b0; data = '0; ready_low = 0; busy_cnt = 0;
    while (1) begin
      if (rv[inst]) begin
        got  = 1'b1;
        hit  = rh[inst];
        data = rd[inst];
        break;
      end
      if (!rdy[inst]) ready_low++;
      if (bsy[inst]) busy_cnt++;
      if (lat >= 20) break;
      if (lat == flush_edge) begin
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end else if (lat == reset_edge) begin
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      lat++;
    end
  endtask

  task automatic runAccess(input string name, input int inst, input logic f,
                           input logic [31:0] a, input logic [31:0] d, input int flush_edge,
                           input logic exp_hit, input int exp_lat, input logic [31:0] exp_data);
    int lat, rl, bc;
    logic h;
    logic [31:0] dd;
    bit got;
    applyStimulus(inst, f, a, d, 1'b0, flush_edge, 0, lat, h, dd, rl, bc, got);
    checkOutput({name, " resp"}, inst, 32'(got), 32'd1);
    checkOutput({name, " latency"}, inst, 32'(lat), 32'(exp_lat));
    checkOutput({name, " hit"}, inst, 32'(h), 32'(exp_hit));
    checkOutput({name, " data"}, inst, dd, exp_data);
    checkOutput({name, " ready_low"}, inst, 32'(rl), 32'(exp_lat - 1));
  endtask

  initial begin
    int lat, rl, bc;
    logic h;
    logic [31:0] dd;
    bit got;

    //          rst  fcn  addr     data          fl   hit  lat  data
    vecs[0]  = '{1'b1, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 1'b0, 1, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h08, 32'h0,        1'b0, 1'b0, 4, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b0, 32'h08, 32'h0,        1'b0, 1'b1, 1, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'h00, 32'hA0000000, 1'b0, 1'b0, 1, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h04, 32'hA4000004, 1'b0, 1'b0, 1, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0C, 32'hAC00000C, 1'b0, 1'b0, 1, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'h10, 32'hB0000010, 1'b0, 1'b0, 1, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 4, 32'hA0000000};
    vecs[8]  = '{1'b0, 1'b0, 32'h04, 32'h0,        1'b0, 1'b0, 4, 32'hA4000004};
    vecs[9]  = '{1'b0, 1'b0, 32'h08, 32'h0,        1'b0, 1'b0, 4, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 1'b0, 32'h0C, 32'h0,        1'b0, 1'b0, 4, 32'hAC00000C};
    vecs[11] = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 4, 32'hB0000010};
    vecs[12] = '{1'b0, 1'b0, 32'h04, 32'h0,        1'b0, 1'b1, 1, 32'hA4000004};
    vecs[13] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 4, 32'hA0000000};
    vecs[14] = '{1'b0, 1'b0, 32'h04, 32'h0,        1'b0, 1'b0, 4, 32'hA4000004};
    vecs[15] = '{1'b0, 1'b0, 32'h08, 32'h0,        1'b0, 1'b0, 4, 32'hDEADBEEF};
    vecs[16] = '{1'b0, 1'b1, 32'h04, 32'h12345678, 1'b0, 1'b0, 1, 32'h0};
    vecs[17] = '{1'b0, 1'b0, 32'h04, 32'h0,        1'b0, 1'b1, 1, 32'h12345678};
    vecs[18] = '{1'b0, 1'b0, 32'h44, 32'h0,        1'b0, 1'b1, 1, 32'h12345678};
    vecs[19] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 4, 32'hA0000000};
    vecs[20] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 1, 32'hA0000000};
    vecs[21] = '{1'b0, 1'b0, 32'h04, 32'h0,        1'b0, 1'b0, 4, 32'h12345678};
    vecs[22] = '{1'b0, 1'b1, 32'h08, 32'hCAFEF00D, 1'b1, 1'b0, 1, 32'h0};
    vecs[23] = '{1'b0, 1'b0, 32'h08, 32'h0,        1'b0, 1'b0, 4, 32'hCAFEF00D};
    vecs[24] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 4, 32'hA0000000};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset req_ready", 0, 32'(rdy[0]), 32'd1);
    checkOutput("reset resp_valid", 0, 32'(rv[0]), 32'd0);
    checkOutput("reset resp_hit", 0, 32'(rh[0]), 32'd0);
    checkOutput("reset resp_data", 0, rd[0], 32'd0);
    checkOutput("reset busy", 0, 32'(bsy[0]), 32'd0);
    checkOutput("reset req_ready nolb", 1, 32'(rdy[1]), 32'd1);
    checkOutput("reset req_ready lat2", 2, 32'(rdy[2]), 32'd1);

    for (int i = 0; i < 25; i++) begin
      if (vecs[i].rst) pulseReset();
      applyStimulus(0, vecs[i].fcn, vecs[i].addr, vecs[i].data, vecs[i].fl, 0, 0,
                    lat, h, dd, rl, bc, got);
      checkOutput("vec resp", i, 32'(got), 32'd1);
      checkOutput("vec latency", i, 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput("vec hit", i, 32'(h), 32'(vecs[i].exp_hit));
      checkOutput("vec data", i, dd, vecs[i].exp_data);
      checkOutput("vec ready_low", i, 32'(rl), 32'(vecs[i].exp_lat - 1));
      checkOutput("vec busy", i, 32'(bc), 32'(vecs[i].exp_lat - 1));
    end

    // Flush mid-miss: response is still correct but the fill is dropped.
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    runAccess("midflush load", 0, 1'b0, 32'h08, 32'h0, 2, 1'b0, 4, 32'hCAFEF00D);
    runAccess("after midflush", 0, 1'b0, 32'h08, 32'h0, 0, 1'b0, 4, 32'hCAFEF00D);
    runAccess("refilled hit", 0, 1'b0, 32'h08, 32'h0, 0, 1'b1, 1, 32'hCAFEF00D);
    @(posedge clk);
    #1 checkOutput("resp pulse width", 0, 32'(rv[0]), 32'd0);

    // Reset two edges into a miss: no response, ready restored, buffer emptied.
    applyStimulus(0, 1'b0, 32'h04, 32'h0, 1'b0, 0, 2, lat, h, dd, rl, bc, got);
    checkOutput("reset-miss no resp", 0, 32'(got), 32'd0);
    checkOutput("reset-miss ready_low", 0, 32'(rl), 32'd2);
    checkOutput("reset-miss busy", 0, 32'(bc), 32'd2);
    runAccess("post-reset load", 0, 1'b0, 32'h08, 32'h0, 0, 1'b0, 4, 32'hCAFEF00D);

    // Buffer disabled: every load is a full-latency miss.
    runAccess("nolb store", 1, 1'b1, 32'h08, 32'h11112222, 0, 1'b0, 1, 32'h0);
    for (int k = 0; k < 3; k++)
      runAccess("nolb load", 1, 1'b0, 32'h08, 32'h0, 0, 1'b0, 4, 32'h11112222);

    // Two-cycle miss latency.
    runAccess("lat2 store", 2, 1'b1, 32'h08, 32'h33334444, 0, 1'b0, 1, 32'h0);
    runAccess("lat2 miss", 2, 1'b0, 32'h08, 32'h0, 0, 1'b0, 2, 32'h33334444);
    runAccess("lat2 hit", 2, 1'b0, 32'h08, 32'h0, 0, 1'b1, 1, 32'h33334444);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sodor_dmem_lb.md
# sodor_dmem_lb

Parametrised data-memory model with a multi-entry load buffer and a configurable miss latency, for the two-copy sodor5 security-verification harness. It generalises the current single-entry load-buffer / fixed-latency data memory: hits return in one cycle, misses in `MISS_LAT` cycles. This produces the load-timing channel that the BMC noninterference properties check across the two model instances. One instance sits behind each model's `dmem_req`/`dmem_resp` port.

## Interface
Parameters:
- `XLEN`, 32, data and address width
- `ADDR_BITS`, 4, word-index bits; memory has 2^ADDR_BITS words
- `MISS_LAT`, 4, load-miss latency in cycles; legal values 2..15
- `LB_ENTRIES`, 4, load-buffer entries; power of two, 1..16
- `LB_EN`, 1, 0 = buffer disabled, so every load is a miss

Ports:
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in 1: request present
- `req_fcn` in 1: 0 = load, 1 = store
- `req_addr` in XLEN: byte address; index = `req_addr[ADDR_BITS+1:2]`; other bits ignored
- `req_data` in XLEN: store data
- `flush` in 1: invalidate all load-buffer entries
- `req_ready` out 1: request accepted when `req_valid && req_ready`
- `resp_valid` out 1: one-cycle response pulse
- `resp_data` out XLEN: load data; 0 for stores
- `resp_hit` out 1: qualifies `resp_valid`; 1 = load-buffer hit
- `busy` out 1: miss in progress

## Operation
- Storage:
  - `mem[2^ADDR_BITS]` is not reset; formal leaves it symbolic.
  - Load buffer: per entry `valid`, `tag[ADDR_BITS]`, `data[XLEN]`.
  - Round-robin pointer `rr[$clog2(LB_ENTRIES)]`.
  - Miss counter `cnt` of 4 bits, holding index, and a `was_flushed` flag.
- States: `IDLE`, `MISS`.
- `IDLE`, `req_ready=1`. On an accepted request:
  - Load hit (`LB_EN`, an entry valid with tag == index, no `flush` this cycle): `resp_valid`/`resp_hit`=1 next cycle, `resp_data` = entry data. Stay `IDLE`.
  - Load miss: latch index, `cnt<=1`, clear `was_flushed`, go to `MISS`.
  - Store: `mem[index]<=req_data`. Every valid entry with matching tag gets its data updated. `resp_valid`=1, `resp_hit`=0, `resp_data`=0 next cycle. Stay `IDLE`.
- `MISS`, `req_ready=0`, `busy=1`:
  - `cnt` increments each cycle.
  - When `cnt==MISS_LAT-1`, the state returns to `IDLE` at that edge and `resp_valid`=1 with `resp_data=mem[index]`, `resp_hit`=0.
  - At the same edge, if `LB_EN` and `!was_flushed` and no `flush` this cycle, allocate an entry:
    - Victim is the lowest-numbered invalid entry; if none is invalid, entry `rr`, and `rr` increments modulo `LB_ENTRIES`.
    - The fill writes `valid=1`, the latched index as tag, and the read data.
  - A `flush` during `MISS` sets `was_flushed`; that fill is suppressed.
- `flush` has priority:
  - All valids clear at the edge.
  - A load in the same cycle is treated as a miss.
  - A store in the same cycle still writes `mem`.
- Buffer contents never diverge from `mem`, because stores update matching entries in place.
- Index aliasing via the ignored upper address bits is intentional.

## Timing
- Reset values:
  - `req_ready=1`, `resp_valid=0`, `resp_hit=0`, `resp_data=0`, `busy=0`.
  - State `IDLE`, all `valid=0`, `rr=0`, `cnt=0`.
- Outputs are registered.
- Request accepted at edge T:
  - Hit or store: `resp_valid` during cycle T+1.
  - Miss: `resp_valid` during cycle T+MISS_LAT; `req_ready` is low T+1..T+MISS_LAT-1 and high at T+MISS_LAT.
- Back-to-back hits and stores sustain one per cycle. A new request may be accepted in the cycle a miss response is presented.
- `reset` mid-miss aborts the miss: no response, no fill. Memory contents are retained.
- `req_valid` while `req_ready=0` is ignored; the requester holds it.

## Test plan
- Reset, store 0xDEADBEEF to 0x8, then load 0x8 (MISS_LAT=4) -> store resp at T+1; load `resp_valid` at T+4 with data 0xDEADBEEF and `resp_hit=0`; an immediate reload hits at T+1 with `resp_hit=1`.
- Fill all 4 entries with loads 0x0/0x4/0x8/0xC, then load 0x10 (index 4) -> entry 0 evicted and `rr`=1; a load of 0x0 then misses (latency 4); a load of 0x4 still hits.
- Hit on 0x4, then store 0x12345678 to 0x4, then load 0x4 -> 1-cycle hit returning 0x12345678.
- `flush` asserted in cycle T+2 of a miss on 0x8 -> response at T+4 with correct data; a following load of 0x8 misses again; `flush` on the same cycle as a load of a cached address -> miss latency.
- `LB_EN=0` with 3 repeated loads of 0x8 -> each response after 4 cycles, `resp_hit` always 0; `MISS_LAT=2` gives a response at T+2 and `req_ready` low for 1 cycle.
- `reset` pulsed at T+2 of a miss -> no `resp_valid` for the rest of the run, `req_ready=1` after the reset edge, buffer empty (next load misses).
